// File: rtl/fetch_queue.sv
// Instruction store plus fetch unit: run-time loadable RAM, free-running fetch PC,
// one-entry inflight read stage and an in-order FIFO drained by a valid/ready handshake.
module fetch_queue #(
  parameter int          DATA_W     = 32,
  parameter int          ADDR_W     = 8,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] RESET_PC   = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load_en,
  input  logic [ADDR_W-1:0]             load_addr,
  input  logic [DATA_W-1:0]             load_data,
  input  logic                          redirect,
  input  logic [31:0]                   redirect_pc,
  input  logic                          inst_ready,
  output logic                          inst_valid,
  output logic [DATA_W-1:0]             inst,
  output logic [31:0]                   inst_pc,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] ram [2**ADDR_W];

  logic [31:0]       pc_q;
  logic              inf_v;
  logic [DATA_W-1:0] inf_data;
  logic [31:0]       inf_pc;

  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [31:0]       fifo_pc   [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count_q;

  logic              in_range;
  logic [DATA_W-1:0] rd_data;
  logic [CNT_W:0]    occ;
  logic              issue, push, pop;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (redirect) state_d = FLUSH;
      FLUSH:   state_d = redirect ? FLUSH : RUN;
      default: state_d = RUN;
    endcase
  end

  // Addresses beyond the RAM read as zero (NOP) rather than aliasing.
  assign in_range = ((pc_q >> ADDR_W) == 32'd0);
  assign rd_data  = in_range ? ram[pc_q[ADDR_W-1:0]] : '0;

  // Credit counts the inflight read and ignores any same-cycle pop.
  assign occ   = {1'b0, count_q} + {{CNT_W{1'b0}}, inf_v};
  assign issue = (state_q == RUN) && !redirect && !load_en
                 && (occ < (CNT_W+1)'(FIFO_DEPTH));
  assign push  = inf_v && !redirect;
  assign pop   = (count_q != '0) && inst_ready;

  always_ff @(posedge clk) begin
    if (load_en) ram[load_addr] <= load_data;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= inf_data;
      fifo_pc[wr_ptr]   <= inf_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      inf_v    <= 1'b0;
      inf_data <= '0;
      inf_pc   <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      if (redirect) begin
        pc_q    <= redirect_pc;
        inf_v   <= 1'b0;
        rd_ptr  <= '0;
        wr_ptr  <= '0;
        count_q <= '0;
      end else begin
        inf_v <= issue;
        if (issue) begin
          inf_data <= rd_data;
          inf_pc   <= pc_q;
          pc_q     <= pc_q + 32'd1;
        end
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   count_q <= count_q + CNT_W'(1);
          2'b01:   count_q <= count_q - CNT_W'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  assign inst_valid = (count_q != '0);
  assign inst       = inst_valid ? fifo_data[rd_ptr] : '0;
  assign inst_pc    = inst_valid ? fifo_pc[rd_ptr]   : '0;
  assign count      = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (ADDR_W = 4, FIFO_DEPTH = 4): fill, backpressure,
// redirect with pop, fetch past RAM depth, load stall and mid-stream reset.
module tb_fetch_queue;

  logic        clk;
  logic        rst_n;
  logic        load_en;
  logic [3:0]  load_addr;
  logic [31:0] load_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_ready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [2:0]  count;

  int unsigned vectors;
  int unsigned errs;
  logic [31:0] prog [16];

  fetch_queue #(
    .DATA_W    (32),
    .ADDR_W    (4),
    .FIFO_DEPTH(4),
    .RESET_PC  (32'd0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .inst_ready (inst_ready),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [31:0] exp_inst, input logic [31:0] exp_pc);
    chk({tag, ".valid"}, {31'd0, inst_valid}, 32'd1);
    chk({tag, ".inst"}, inst, exp_inst);
    chk({tag, ".pc"}, inst_pc, exp_pc);
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, ".valid"}, {31'd0, inst_valid}, 32'd0);
    chk({tag, ".inst"}, inst, 32'd0);
    chk({tag, ".pc"}, inst_pc, 32'd0);
    chk({tag, ".count"}, {29'd0, count}, 32'd0);
  endtask

  initial begin
    vectors     = 0;
    errs        = 0;
    rst_n       = 1'b0;
    load_en     = 1'b0;
    load_addr   = '0;
    load_data   = '0;
    redirect    = 1'b0;
    redirect_pc = '0;
    inst_ready  = 1'b1;

    prog[0] = 32'h71041000;
    prog[1] = 32'h41420C00;
    prog[2] = 32'h30147000;
    prog[3] = 32'h00000000;
    for (int i = 4; i < 16; i++) prog[i] = 32'hA0000000 + 32'(i);

    // program load while held in reset
    for (int i = 0; i < 16; i++) begin
      load_en   = 1'b1;
      load_addr = 4'(i);
      load_data = prog[i];
      tick();
    end
    load_en = 1'b0;
    chk_empty("reset");

    // fill: first issue at E1, head visible after E2
    rst_n = 1'b1;
    tick();
    chk("fill.e1.valid", {31'd0, inst_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_head($sformatf("fill%0d", i), prog[i], 32'(i));
    end
    chk("fill.count", {29'd0, count}, 32'd1);

    // backpressure from a fresh start at pc 0
    redirect    = 1'b1;
    redirect_pc = 32'd0;
    inst_ready  = 1'b0;
    tick();
    redirect = 1'b0;
    chk("bp.flushed", {29'd0, count}, 32'd0);
    for (int i = 0; i < 10; i++) tick();
    chk("bp.full", {29'd0, count}, 32'd4);
    chk_head("bp.head", prog[0], 32'd0);
    tick();
    chk("bp.full2", {29'd0, count}, 32'd4);
    chk_head("bp.stable", prog[0], 32'd0);
    inst_ready = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk_head($sformatf("drain%0d", i), prog[i], 32'(i));
    end

    // redirect with same-cycle pop at count 3
    inst_ready = 1'b0;
    tick();
    chk("rd.pre.count", {29'd0, count}, 32'd3);
    redirect    = 1'b1;
    redirect_pc = 32'd11;
    inst_ready  = 1'b1;
    tick();
    redirect = 1'b0;
    chk_empty("rd.e0");
    tick();
    chk("rd.e1.count", {29'd0, count}, 32'd0);
    tick();
    chk("rd.e2.count", {29'd0, count}, 32'd0);
    tick();
    chk_head("rd.e3", prog[11], 32'd11);

    // fetch past the 16-word RAM returns zero
    for (int p = 12; p <= 17; p++) begin
      tick();
      chk_head($sformatf("seq%0d", p), (p < 16) ? prog[p] : 32'd0, 32'(p));
    end

    // five-cycle load stalls issue; queue drains
    for (int i = 0; i < 5; i++) begin
      load_en   = 1'b1;
      load_addr = 4'(5 + i);
      load_data = 32'hC0000000 + 32'(5 + i);
      prog[5 + i] = load_data;
      tick();
    end
    load_en = 1'b0;
    chk_empty("load.stall");
    redirect    = 1'b1;
    redirect_pc = 32'd7;
    tick();
    redirect = 1'b0;
    tick();
    tick();
    tick();
    chk_head("load.new", prog[7], 32'd7);

    // asynchronous reset mid-stream at count 2
    inst_ready = 1'b0;
    tick();
    chk("rst.pre.count", {29'd0, count}, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_empty("rst.async");
    tick();
    tick();
    inst_ready = 1'b1;
    rst_n      = 1'b1;
    tick();
    chk("rst.e1.valid", {31'd0, inst_valid}, 32'd0);
    for (int i = 0; i <= 5; i++) begin
      tick();
      chk_head($sformatf("rst.seq%0d", i), prog[i], 32'(i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
